gate_truth_table_checker: RTL

Self-test companion for the single-gate tiles: drives every two-input combination onto a gate under test, waits a settle interval, samples the gate's output and compares it against the expected truth table for a selected function. It sits on the driving side of the gate: its stimulus feeds the gate's A/B inputs, and its `dut_y_i` input takes the gate's Y output. It reports error count, first failing vector and a pass flag through a start/busy/done handshake.

---
 rtl/gate_chk_pkg.sv | 38 +++
 rtl/gate_chk_sync.sv | 27 ++
 rtl/gate_truth_table_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: gate function
// encodings, the checker FSM state type and the reference truth table.
package gate_chk_pkg;

   // Gate function encodings carried on func_i
   localparam logic [2:0] FUNC_NAND  = 3'd0;
   localparam logic [2:0] FUNC_AND   = 3'd1;
   localparam logic [2:0] FUNC_OR    = 3'd2;
   localparam logic [2:0] FUNC_NOR   = 3'd3;
   localparam logic [2:0] FUNC_XOR   = 3'd4;
   localparam logic [2:0] FUNC_XNOR  = 3'd5;
   localparam logic [2:0] FUNC_NOT_A = 3'd6;
   localparam logic [2:0] FUNC_BUF_A = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   // Ideal gate output for the selected function and inputs {b, a}
   function automatic logic expected(input logic [2:0] func, input logic b, input logic a);
      logic y;
      case (func)
         FUNC_NAND:  y = ~(a & b);
         FUNC_AND:   y = a & b;
         FUNC_OR:    y = a | b;
         FUNC_NOR:   y = ~(a | b);
         FUNC_XOR:   y = a ^ b;
         FUNC_XNOR:  y = ~(a ^ b);
         FUNC_NOT_A: y = ~a;
         default:    y = a;  // FUNC_BUF_A
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gate_chk_sync.sv
// Two-flop synchronizer for the gate output when it returns through pads.
// Only instantiated when GATE_CHK_SYNC_EN is defined.
module gate_chk_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops, both cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/gate_truth_table_checker.sv
// Gate truth-table checker: sweeps {B,A} = 00,01,10,11 onto a gate under
// test for a number of passes, waits a settle interval per vector, samples
// the gate output and counts mismatches against the selected function.
// Optional build macro: GATE_CHK_SYNC_EN (synchronize dut_y_i through two
// flops and lengthen the settle interval by two cycles).
module gate_truth_table_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       func_i,
   input  logic [3:0]       passes_i,
   input  logic             dut_y_i,
   output logic [1:0]       stim_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic             fail_valid_o,
   output logic [1:0]       fail_vec_o
);

`ifdef GATE_CHK_SYNC_EN
   // Two extra cycles let the synchronizer catch up with the new stimulus
   localparam int unsigned SETTLE_TARGET = SETTLE_CYCLES + 2;
`else
   localparam int unsigned SETTLE_TARGET = SETTLE_CYCLES;
`endif
   localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_TARGET - 1);

   logic y_cmp;

`ifdef GATE_CHK_SYNC_EN
   gate_chk_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (dut_y_i),
      .q_o (y_cmp)
   );
`else
   assign y_cmp = dut_y_i;
`endif

   state_e           state_q,      state_d;
   logic [2:0]       func_q,       func_d;
   logic [3:0]       last_pass_q,  last_pass_d;
   logic [3:0]       pass_idx_q,   pass_idx_d;
   logic [8:0]       settle_cnt_q, settle_cnt_d;
   logic [1:0]       stim_q,       stim_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;
   logic             pass_q,       pass_d;
   logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
   logic             fail_valid_q, fail_valid_d;
   logic [1:0]       fail_vec_q,   fail_vec_d;

   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Saturating error count including the vector being sampled this cycle
   always_comb begin
      mismatch = (y_cmp != expected(func_q, stim_q[1], stim_q[0]));
      err_next = err_cnt_q;
      if (mismatch && (err_cnt_q != '1)) begin
         err_next = err_cnt_q + ERR_W'(1);
      end
   end

   // Next-state and next-output logic for the sweep FSM
   always_comb begin
      // NOTE: every _d gets a default from its _q first, so no path leaves a latch behind.
      state_d      = state_q;
      func_d       = func_q;
      last_pass_d  = last_pass_q;
      pass_idx_d   = pass_idx_q;
      settle_cnt_d = settle_cnt_q;
      stim_d       = stim_q;
      pass_d       = pass_q;
      err_cnt_d    = err_cnt_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;

      case (state_q)
         ST_IDLE: begin
            stim_d = 2'b00;
            if (start_i) begin
               func_d       = func_i;
               // A pass count of zero still runs one sweep
               last_pass_d  = (passes_i == 4'd0) ? 4'd0 : passes_i - 4'd1;
               pass_idx_d   = 4'd0;
               settle_cnt_d = 9'd0;
               err_cnt_d    = '0;
               pass_d       = 1'b0;
               fail_valid_d = 1'b0;
               fail_vec_d   = 2'b00;
               state_d      = ST_DRIVE;
            end
         end

         ST_DRIVE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = 9'd0;
               state_d      = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 9'd1;
            end
         end

         ST_SAMPLE: begin
            err_cnt_d = err_next;
            if (mismatch && !fail_valid_q) begin
               fail_valid_d = 1'b1;
               fail_vec_d   = stim_q;
            end
            stim_d = stim_q + 2'd1;
            if (stim_q == 2'b11) begin
               if (pass_idx_q == last_pass_q) begin
                  pass_d  = (err_next == '0);
                  state_d = ST_DONE;
               end else begin
                  pass_idx_d = pass_idx_q + 4'd1;
                  state_d    = ST_DRIVE;
               end
            end else begin
               state_d = ST_DRIVE;
            end
         end

         default: begin  // ST_DONE
            stim_d  = 2'b00;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset clears everything immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         func_q       <= 3'd0;
         last_pass_q  <= 4'd0;
         pass_idx_q   <= 4'd0;
         settle_cnt_q <= 9'd0;
         stim_q       <= 2'b00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         func_q       <= func_d;
         last_pass_q  <= last_pass_d;
         pass_idx_q   <= pass_idx_d;
         settle_cnt_q <= settle_cnt_d;
         stim_q       <= stim_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
      end
   end

   assign stim_o       = stim_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign err_cnt_o    = err_cnt_q;
   assign fail_valid_o = fail_valid_q;
   assign fail_vec_o   = fail_vec_q;

endmodule
